// File: rtl/cdf_pkg.sv
// Shared constants and FSM state type for the CDF accumulate stage.
package cdf_pkg;
   localparam int DEF_BIN_W = 16;
   localparam int DEF_SUM_W = 20;
   localparam int ADDR_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } cdf_state_e;
endpackage

// File: rtl/cdf_accumulate_if.sv
// Histogram-memory read port plus the result beat bus that feeds the CDF store stage.
interface cdf_accumulate_if
   import cdf_pkg::*;
#(
   parameter int BIN_W = DEF_BIN_W,
   parameter int SUM_W = DEF_SUM_W
) ();
   logic              ReadEnable;
   logic [ADDR_W-1:0] ReadAddress;
   logic [BIN_W-1:0]  ReadData;
   logic              StartOut;
   logic [SUM_W-1:0]  ResultOut;
   logic [ADDR_W-1:0] StoreAddressOut;

   modport master (
      output ReadEnable, ReadAddress, StartOut, ResultOut, StoreAddressOut,
      input  ReadData
   );

   modport slave (
      input  ReadEnable, ReadAddress, StartOut, ResultOut, StoreAddressOut,
      output ReadData
   );
endinterface

// File: rtl/cdf_accumulate.sv
// Streams NUM_BINS histogram bins, emits running-sum beats for the store stage and tracks CdfMin.
// Build option CDF_SATURATE_EN: the running sum clamps at its maximum instead of wrapping.
module cdf_accumulate
   import cdf_pkg::*;
#(
   parameter int NUM_BINS = 256,
   parameter int BIN_W    = DEF_BIN_W,
   parameter int SUM_W    = DEF_SUM_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] HistBaseAddr,
   input  logic [ADDR_W-1:0] StoreBaseAddr,
   cdf_accumulate_if.master  bus,
   output logic [SUM_W-1:0]  CdfMin,
   output logic              Busy,
   output logic              done
);
   localparam int               CNT_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BINS - 1);

   cdf_state_e        state_r, state_s;
   logic              rd_en_s, accept_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [CNT_W-1:0]  rd_cnt_s;
   logic              read_en_r, issued_r;
   logic [ADDR_W-1:0] read_addr_r;
   logic [CNT_W-1:0]  rd_cnt_r;
   logic [SUM_W-1:0]  sum_r, sum_s;
   logic [ADDR_W-1:0] st_addr_r;
   logic              start_out_r;
   logic [SUM_W-1:0]  result_r;
   logic [ADDR_W-1:0] store_addr_r;
   logic              min_found_r;
   logic [SUM_W-1:0]  min_val_r, cdf_min_r;
   logic              busy_r, done_r;

   function automatic logic [SUM_W-1:0] add_bin(input logic [SUM_W-1:0] acc,
                                                input logic [BIN_W-1:0] bin);
`ifdef CDF_SATURATE_EN
      logic [SUM_W:0] wide;
      wide = {1'b0, acc} + (SUM_W+1)'(bin);
      if (wide[SUM_W]) begin
         add_bin = {SUM_W{1'b1}};
      end else begin
         add_bin = wide[SUM_W-1:0];
      end
`else
      add_bin = acc + SUM_W'(bin);
`endif
   endfunction

   assign sum_s = add_bin(sum_r, bus.ReadData);

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and next read-port values
   always_comb begin
      state_s   = state_r;
      rd_en_s   = 1'b0;
      rd_addr_s = '0;
      rd_cnt_s  = rd_cnt_r;
      accept_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (Start) begin
               state_s   = READ;
               accept_s  = 1'b1;
               rd_en_s   = 1'b1;
               rd_addr_s = HistBaseAddr;
               rd_cnt_s  = '0;
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            if (rd_cnt_r == LAST_CNT) begin
               state_s = DRAIN;
            end else begin
               rd_en_s   = 1'b1;
               rd_addr_s = read_addr_r + ADDR_W'(1);
               rd_cnt_s  = rd_cnt_r + CNT_W'(1);
            end
         end
         // The last beat is on the bus once no read is in flight
         DRAIN: begin
            if (!issued_r && start_out_r) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Read port, accumulator, result beat and status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         read_en_r    <= 1'b0;
         read_addr_r  <= '0;
         rd_cnt_r     <= '0;
         issued_r     <= 1'b0;
         sum_r        <= '0;
         st_addr_r    <= '0;
         start_out_r  <= 1'b0;
         result_r     <= '0;
         store_addr_r <= '0;
         min_found_r  <= 1'b0;
         min_val_r    <= '0;
         cdf_min_r    <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         read_en_r   <= rd_en_s;
         read_addr_r <= rd_addr_s;
         rd_cnt_r    <= rd_cnt_s;
         issued_r    <= read_en_r;
         busy_r      <= (state_s == READ) || (state_s == DRAIN);
         done_r      <= (state_s == DONE);

         if (accept_s) begin
            sum_r       <= '0;
            st_addr_r   <= StoreBaseAddr;
            min_found_r <= 1'b0;
            min_val_r   <= '0;
         end else if (issued_r) begin
            sum_r     <= sum_s;
            st_addr_r <= st_addr_r + ADDR_W'(1);
            if (!min_found_r && (sum_s != '0)) begin
               min_found_r <= 1'b1;
               min_val_r   <= sum_s;
            end else begin
               min_found_r <= min_found_r;
            end
         end else begin
            sum_r <= sum_r;
         end

         // Idle beats carry zeros because the store stage registers unconditionally
         if (issued_r) begin
            start_out_r  <= 1'b1;
            result_r     <= sum_s;
            store_addr_r <= st_addr_r;
         end else begin
            start_out_r  <= 1'b0;
            result_r     <= '0;
            store_addr_r <= '0;
         end

         if (state_s == DONE) begin
            cdf_min_r <= min_val_r;
         end else begin
            cdf_min_r <= cdf_min_r;
         end
      end
   end

   assign bus.ReadEnable      = read_en_r;
   assign bus.ReadAddress     = read_addr_r;
   assign bus.StartOut        = start_out_r;
   assign bus.ResultOut       = result_r;
   assign bus.StoreAddressOut = store_addr_r;
   assign CdfMin              = cdf_min_r;
   assign Busy                = busy_r;
   assign done                = done_r;
endmodule

// File: tb/tb_cdf_accumulate.sv
// Self-checking bench for cdf_accumulate: directed table, random passes, restart/reset sequences.
module tb_cdf_accumulate;
   localparam int     NB   = 256;
   localparam int     BW   = 16;
   localparam int     SW   = 20;
   localparam longint SMAX = (64'd1 << SW) - 64'd1;

   localparam int P_ONES  = 0;
   localparam int P_SPIKE = 1;
   localparam int P_MAX   = 2;
   localparam int P_ZERO  = 3;
   localparam int P_SMALL = 4;
   localparam int P_RAND  = 5;

   typedef struct {
      int          pat;
      logic [15:0] hb;
      logic [15:0] sb;
      int          idx;
      logic [19:0] exp_res;
      logic [15:0] exp_sa;
      logic [19:0] exp_min;
      logic [19:0] exp_last;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          Start;
   logic [15:0]   HistBaseAddr, StoreBaseAddr;
   logic [SW-1:0] CdfMin;
   logic          Busy, done;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] mem [0:65535];
   logic [SW-1:0] exp_res [0:NB-1];
   logic [SW-1:0] exp_min, prev_min;
   logic [SW-1:0] got_res [0:NB-1];
   logic [15:0]   got_sa [0:NB-1];
   int            got_beats, got_dones;
   vec_t          vecs [0:7];

   cdf_accumulate_if #(.BIN_W(BW), .SUM_W(SW)) bus ();

   cdf_accumulate #(.NUM_BINS(NB), .BIN_W(BW), .SUM_W(SW)) dut (
      .clock(clock), .reset(reset), .Start(Start),
      .HistBaseAddr(HistBaseAddr), .StoreBaseAddr(StoreBaseAddr),
      .bus(bus), .CdfMin(CdfMin), .Busy(Busy), .done(done)
   );

   always #5 clock = ~clock;

   // Histogram memory: one-cycle read latency
   always @(posedge clock) begin
      if (bus.ReadEnable) bus.ReadData <= mem[bus.ReadAddress];
   end

   task automatic chk(input string name, input int cyc, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fill(input int pat, input logic [15:0] hb);
      int lead;
      lead = $urandom_range(0, NB - 1);
      for (int i = 0; i < NB; i++) begin
         logic [15:0] a;
         a = hb + 16'(i);
         case (pat)
            P_ONES:  mem[a] = 16'd1;
            P_SPIKE: mem[a] = (i == 10) ? 16'd5 : 16'd0;
            P_MAX:   mem[a] = 16'hFFFF;
            P_ZERO:  mem[a] = 16'd0;
            P_SMALL: mem[a] = (i < lead) ? 16'd0 : 16'($urandom_range(0, 3));
            default: mem[a] = 16'($urandom);
         endcase
      end
   endtask

   // Reference: running sum over the bins with plain arithmetic
   task automatic build_model(input logic [15:0] hb);
      longint acc;
      bit     found;
      acc = 0;
      found = 1'b0;
      exp_min = '0;
      for (int i = 0; i < NB; i++) begin
         logic [15:0] a;
         a = hb + 16'(i);
         acc = acc + longint'(mem[a]);
`ifdef CDF_SATURATE_EN
         if (acc > SMAX) acc = SMAX;
`else
         acc = acc & SMAX;
`endif
         exp_res[i] = SW'(acc);
         if (!found && acc != 0) begin
            found = 1'b1;
            exp_min = SW'(acc);
         end
      end
   endtask

   task automatic run_pass(input logic [15:0] hb, input logic [15:0] sb,
                           input int repulse_beat, input int reset_beat);
      int rst_k;
      bit aborted;
      build_model(hb);
      got_beats = 0;
      got_dones = 0;
      aborted = 1'b0;
      rst_k = (reset_beat >= 0) ? reset_beat + 3 : -1;
      @(negedge clock);
      HistBaseAddr = hb;
      StoreBaseAddr = sb;
      Start = 1'b1;
      for (int k = 1; k <= NB + 6; k++) begin
         @(negedge clock);
         Start = 1'b0;
         reset = 1'b0;
         HistBaseAddr = 16'($urandom);
         StoreBaseAddr = 16'($urandom);
         if (aborted) begin
            chk("abort_re", k, bus.ReadEnable, 0);
            chk("abort_ra", k, bus.ReadAddress, 0);
            chk("abort_so", k, bus.StartOut, 0);
            chk("abort_res", k, bus.ResultOut, 0);
            chk("abort_sa", k, bus.StoreAddressOut, 0);
            chk("abort_min", k, CdfMin, 0);
            chk("abort_busy", k, Busy, 0);
            chk("abort_done", k, done, 0);
         end else begin
            chk("read_en", k, bus.ReadEnable, (k <= NB) ? 1 : 0);
            if (k <= NB) chk("read_addr", k, bus.ReadAddress, 16'(hb + 16'(k - 1)));
            chk("start_out", k, bus.StartOut, (k >= 3 && k <= NB + 2) ? 1 : 0);
            if (k >= 3 && k <= NB + 2) begin
               chk("result", k, bus.ResultOut, exp_res[k - 3]);
               chk("store_addr", k, bus.StoreAddressOut, 16'(sb + 16'(k - 3)));
            end else begin
               chk("idle_result", k, bus.ResultOut, 0);
               chk("idle_store_addr", k, bus.StoreAddressOut, 0);
            end
            chk("done", k, done, (k == NB + 3) ? 1 : 0);
            chk("busy", k, Busy, (k <= NB + 2) ? 1 : 0);
            if (k <= NB + 2) chk("cdfmin_hold", k, CdfMin, prev_min);
            if (k >= NB + 4) chk("cdfmin_new", k, CdfMin, exp_min);
         end
         if (bus.StartOut) begin
            if (got_beats < NB) begin
               got_res[got_beats] = bus.ResultOut;
               got_sa[got_beats]  = bus.StoreAddressOut;
            end
            got_beats++;
         end
         if (done) got_dones++;
         if (repulse_beat >= 0 && (k == repulse_beat + 3 || k == NB + 3)) Start = 1'b1;
         if (k == rst_k) begin
            reset = 1'b1;
            aborted = 1'b1;
         end
      end
      prev_min = aborted ? '0 : exp_min;
   endtask

   initial begin
      reset = 1'b1;
      Start = 1'b0;
      HistBaseAddr = 16'h0000;
      StoreBaseAddr = 16'h0000;
      prev_min = '0;
      vecs[0] = '{P_ONES,  16'h1000, 16'h2000, 100, 20'd101,    16'h2064, 20'd1,      20'd256};
      vecs[1] = '{P_SPIKE, 16'h3000, 16'h6000, 9,   20'd0,      16'h6009, 20'd5,      20'd5};
      vecs[2] = '{P_SPIKE, 16'h3000, 16'h6000, 10,  20'd5,      16'h600A, 20'd5,      20'd5};
`ifdef CDF_SATURATE_EN
      vecs[3] = '{P_MAX,   16'h7000, 16'h8000, 16,  20'hFFFFF,  16'h8010, 20'h0FFFF,  20'hFFFFF};
      vecs[4] = '{P_MAX,   16'h7000, 16'h8000, 15,  20'hFFFF0,  16'h800F, 20'h0FFFF,  20'hFFFFF};
`else
      vecs[3] = '{P_MAX,   16'h7000, 16'h8000, 16,  20'h0FFEF,  16'h8010, 20'h0FFFF,  20'hFFF00};
      vecs[4] = '{P_MAX,   16'h7000, 16'h8000, 15,  20'hFFFF0,  16'h800F, 20'h0FFFF,  20'hFFF00};
`endif
      vecs[5] = '{P_ONES,  16'hFFF0, 16'hFFFA, 6,   20'd7,      16'h0000, 20'd1,      20'd256};
      vecs[6] = '{P_ONES,  16'hFFF0, 16'hFFFA, 5,   20'd6,      16'hFFFF, 20'd1,      20'd256};
      vecs[7] = '{P_ZERO,  16'h9000, 16'hA000, 0,   20'd0,      16'hA000, 20'd0,      20'd0};

      repeat (3) @(negedge clock);
      chk("rst_re", 0, bus.ReadEnable, 0);
      chk("rst_ra", 0, bus.ReadAddress, 0);
      chk("rst_so", 0, bus.StartOut, 0);
      chk("rst_res", 0, bus.ResultOut, 0);
      chk("rst_sa", 0, bus.StoreAddressOut, 0);
      chk("rst_min", 0, CdfMin, 0);
      chk("rst_busy", 0, Busy, 0);
      chk("rst_done", 0, done, 0);
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         fill(vecs[v].pat, vecs[v].hb);
         run_pass(vecs[v].hb, vecs[v].sb, -1, -1);
         chk("tbl_beats", v, got_beats, NB);
         chk("tbl_dones", v, got_dones, 1);
         chk("tbl_res_idx", v, got_res[vecs[v].idx], vecs[v].exp_res);
         chk("tbl_sa_idx", v, got_sa[vecs[v].idx], vecs[v].exp_sa);
         chk("tbl_res_last", v, got_res[NB - 1], vecs[v].exp_last);
         chk("tbl_cdfmin", v, CdfMin, vecs[v].exp_min);
      end

      for (int r = 0; r < 4; r++) begin
         logic [15:0] hb, sb;
         hb = 16'($urandom);
         sb = 16'($urandom);
         fill((r % 2 == 0) ? P_SMALL : P_RAND, hb);
         run_pass(hb, sb, -1, -1);
      end

      // Start re-pulsed mid-pass and in DONE must be ignored
      fill(P_ONES, 16'h4000);
      run_pass(16'h4000, 16'h5000, 50, -1);
      chk("repulse_beats", 0, got_beats, NB);
      chk("repulse_dones", 0, got_dones, 1);

      // Reset at beat 100 aborts the pass
      fill(P_SMALL, 16'h4400);
      run_pass(16'h4400, 16'h5400, -1, 100);
      chk("abort_beats", 0, got_beats, 101);
      chk("abort_dones", 0, got_dones, 0);

      // A fresh pass after the abort starts from a zero sum
      fill(P_ONES, 16'h4800);
      run_pass(16'h4800, 16'h5800, -1, -1);
      chk("fresh_first", 0, got_res[0], 1);
      chk("fresh_last", 0, got_res[NB - 1], 256);
      chk("fresh_min", 0, CdfMin, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
